// File: rtl/sprite_fetch.sv
// ============================================================================
// Module      : sprite_fetch
// Description : Sprite ROM fetch for one sprite. Position updates are applied
//               at frame start only. Output pixels are transparency-keyed.
//               Optional build macro: SPRITE_FETCH_MIRROR_EN (adds mirror_x).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_fetch #(
    parameter int          ADDRESS    = 10,
    parameter int          SIZE_LOG2  = 5,
    parameter int          COLOR_BITS = 24,
    parameter int          COORD_BITS = 10,
    parameter logic [23:0] KEY_COLOR  = 24'hFF00FF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  de,
    input  logic [COORD_BITS-1:0] hcount,
    input  logic [COORD_BITS-1:0] vcount,
    input  logic                  pos_valid,
    output logic                  pos_ready,
    input  logic [COORD_BITS-1:0] pos_x,
    input  logic [COORD_BITS-1:0] pos_y,
`ifdef SPRITE_FETCH_MIRROR_EN
    input  logic                  mirror_x,
`endif
    output logic [ADDRESS-1:0]    rom_addr,
    input  logic [COLOR_BITS-1:0] rom_data,
    output logic                  pix_valid,
    output logic                  pix_opaque,
    output logic [COLOR_BITS-1:0] pix_color
);

    localparam logic [COLOR_BITS-1:0] c_key = KEY_COLOR[COLOR_BITS-1:0];

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                r_state;
    logic [COORD_BITS-1:0] r_pend_x;
    logic [COORD_BITS-1:0] r_pend_y;
    logic [COORD_BITS-1:0] r_act_x;
    logic [COORD_BITS-1:0] r_act_y;
`ifdef SPRITE_FETCH_MIRROR_EN
    logic                  r_pend_mirror;
    logic                  r_act_mirror;
`endif

    // A position offered in the same cycle as frame_start is only latched;
    // it waits for the following frame_start to become active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            pos_ready <= 1'b1;
            r_pend_x  <= '0;
            r_pend_y  <= '0;
            r_act_x   <= '0;
            r_act_y   <= '0;
`ifdef SPRITE_FETCH_MIRROR_EN
            r_pend_mirror <= 1'b0;
            r_act_mirror  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pos_valid) begin
                        r_pend_x  <= pos_x;
                        r_pend_y  <= pos_y;
`ifdef SPRITE_FETCH_MIRROR_EN
                        r_pend_mirror <= mirror_x;
`endif
                        r_state   <= ST_PENDING;
                        pos_ready <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (frame_start) begin
                        r_act_x   <= r_pend_x;
                        r_act_y   <= r_pend_y;
`ifdef SPRITE_FETCH_MIRROR_EN
                        r_act_mirror <= r_pend_mirror;
`endif
                        r_state   <= ST_IDLE;
                        pos_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    pos_ready <= 1'b1;
                end
            endcase
        end
    end

    // Zero-extended subtraction: the MSB is the sign, so a scan position left
    // of or above the sprite never aliases into the window.
    logic [COORD_BITS:0]  w_rel_x;
    logic [COORD_BITS:0]  w_rel_y;
    logic                 w_inside;
    logic [SIZE_LOG2-1:0] w_col;

    assign w_rel_x  = {1'b0, hcount} - {1'b0, r_act_x};
    assign w_rel_y  = {1'b0, vcount} - {1'b0, r_act_y};
    assign w_inside = de
                   && (w_rel_x[COORD_BITS:SIZE_LOG2] == '0)
                   && (w_rel_y[COORD_BITS:SIZE_LOG2] == '0);

`ifdef SPRITE_FETCH_MIRROR_EN
    assign w_col = r_act_mirror ? ~w_rel_x[SIZE_LOG2-1:0] : w_rel_x[SIZE_LOG2-1:0];
`else
    assign w_col = w_rel_x[SIZE_LOG2-1:0];
`endif

    logic r_inside_q;
    logic r_de_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            r_inside_q <= 1'b0;
            r_de_q     <= 1'b0;
        end else begin
            if (w_inside) begin
                rom_addr <= {w_rel_y[SIZE_LOG2-1:0], w_col};
            end
            r_inside_q <= w_inside;
            r_de_q     <= de;
        end
    end

    logic w_opaque;

    assign w_opaque = r_inside_q && (rom_data != c_key);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_valid  <= 1'b0;
            pix_opaque <= 1'b0;
            pix_color  <= '0;
        end else begin
            pix_valid  <= r_de_q;
            pix_opaque <= w_opaque;
            pix_color  <= w_opaque ? rom_data : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_fetch.sv
// ============================================================================
// Module      : tb_sprite_fetch
// Description : Self-checking bench for sprite_fetch against a coordinate-level
//               reference model of sprite placement, ROM lookup and keying.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_fetch;

    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        de;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        pos_valid;
    logic        pos_ready;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [9:0]  rom_addr;
    logic [23:0] rom_data;
    logic        pix_valid;
    logic        pix_opaque;
    logic [23:0] pix_color;

    logic [23:0] rom [1024];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    sprite_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .de          (de),
        .hcount      (hcount),
        .vcount      (vcount),
        .pos_valid   (pos_valid),
        .pos_ready   (pos_ready),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
`ifdef SPRITE_FETCH_MIRROR_EN
        .mirror_x    (1'b0),
`endif
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_valid   (pix_valid),
        .pix_opaque  (pix_opaque),
        .pix_color   (pix_color)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: sprite placement as plain integers
    int ax = 0, ay = 0, px = 0, py = 0;
    bit pend = 1'b0;
    int m_addr = 0;
    bit prev_de = 1'b0, prev_in = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input bit r, input bit fs, input bit d,
                        input bit pv, input int h, input int v, input int nx, input int ny);
        int rx, ry;
        bit inn, e_val, e_op;
        logic [23:0] e_col;
        rst_n = r; frame_start = fs; de = d; pos_valid = pv;
        hcount = h[9:0]; vcount = v[9:0]; pos_x = nx[9:0]; pos_y = ny[9:0];
        @(posedge clk);
        rx  = h - ax;
        ry  = v - ay;
        inn = d && rx >= 0 && rx < 32 && ry >= 0 && ry < 32;
        e_val = prev_de;
        e_op  = prev_in && (rom[m_addr] != KEY);
        e_col = e_op ? rom[m_addr] : 24'h0;
        if (!r) begin
            e_val = 1'b0; e_op = 1'b0; e_col = 24'h0;
            ax = 0; ay = 0; px = 0; py = 0; pend = 1'b0;
            m_addr = 0; prev_de = 1'b0; prev_in = 1'b0;
        end else begin
            if (inn) m_addr = ry * 32 + rx;
            prev_de = d;
            prev_in = inn;
            if (pend && fs) begin
                ax = px; ay = py; pend = 1'b0;
            end else if (!pend && pv) begin
                px = nx; py = ny; pend = 1'b1;
            end
        end
        #1;
        chk({tag, ".pos_ready"},  32'(pos_ready),  32'(!pend));
        chk({tag, ".rom_addr"},   32'(rom_addr),   32'(m_addr));
        chk({tag, ".pix_valid"},  32'(pix_valid),  32'(e_val));
        chk({tag, ".pix_opaque"}, 32'(pix_opaque), 32'(e_op));
        chk({tag, ".pix_color"},  32'(pix_color),  32'(e_col));
    endtask

    task automatic move(input string tag, input int nx, input int ny);
        step({tag, ".offer"}, 1, 0, 0, 1, 0, 0, nx, ny);
        step({tag, ".fs"},    1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int tx, ty;
        for (int i = 0; i < 1024; i++)
            rom[i] = ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom);
        rom[0]   = 24'h112233;
        rom[13]  = 24'h0A0B0C;
        rom[103] = 24'hABCDEF;
        rom[165] = 24'h445566;
        rom[200] = KEY;
        rst_n = 1'b0; frame_start = 1'b0; de = 1'b0; pos_valid = 1'b0;
        hcount = '0; vcount = '0; pos_x = '0; pos_y = '0;

        repeat (3)
            step("reset", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), $urandom_range(0, 1023));
        chk("reset_ready", 32'(pos_ready), 32'd1);
        chk("reset_pix",   32'({pix_valid, pix_opaque, pix_color}), 32'd0);

        // Offer is held pending until frame_start
        step("offer", 1, 0, 0, 1, 0, 0, 100, 50);
        chk("ready_low", 32'(pos_ready), 32'd0);
        repeat (3) step("pre_fs", 1, 0, 1, 0, 100, 50, 0, 0);
        chk("no_opaque_pre_fs", 32'(pix_opaque), 32'd0);
        step("fs", 1, 1, 0, 0, 0, 0, 0, 0);
        step("scan_origin", 1, 0, 1, 0, 100, 50, 0, 0);
        chk("addr_origin", 32'(rom_addr), 32'd0);
        step("drain_origin", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("opaque_origin", 32'(pix_opaque), 32'd1);

        step("scan_103", 1, 0, 1, 0, 107, 53, 0, 0);
        chk("addr_103", 32'(rom_addr), 32'd103);
        step("drain_103", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("color_103", 32'(pix_color), 32'hABCDEF);

        // Key colour inside the window
        step("scan_key", 1, 0, 1, 0, 108, 56, 0, 0);
        step("drain_key", 1, 0, 1, 0, 0, 0, 0, 0);
        chk("key_opaque", 32'(pix_opaque), 32'd0);
        chk("key_color",  32'(pix_color),  32'd0);
        chk("key_valid",  32'(pix_valid),  32'd1);

        // Right-edge clipping
        move("edge", 1010, 0);
        step("scan_1023", 1, 0, 1, 0, 1023, 0, 0, 0);
        chk("addr_1023", 32'(rom_addr), 32'd13);
        step("scan_5", 1, 0, 1, 0, 5, 0, 0, 0);
        chk("opaque_1023", 32'(pix_opaque), 32'd1);
        step("drain_5", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("no_wrap", 32'(pix_opaque), 32'd0);
        chk("addr_hold", 32'(rom_addr), 32'd13);

        move("left", 100, 50);
        step("scan_99", 1, 0, 1, 0, 99, 50, 0, 0);
        step("drain_99", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("neg_rel_x", 32'(pix_opaque), 32'd0);

        // Offer coincident with frame_start waits one more frame
        step("coinc", 1, 1, 0, 1, 0, 0, 0, 0);
        step("coinc_scan_old", 1, 0, 1, 0, 100, 50, 0, 0);
        step("coinc_drain", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("coinc_still_old", 32'(pix_opaque), 32'd1);
        step("coinc_fs", 1, 1, 0, 0, 0, 0, 0, 0);
        step("coinc_scan_new", 1, 0, 1, 0, 5, 5, 0, 0);
        step("coinc_drain2", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("coinc_applied", 32'(pix_opaque), 32'd1);

        // Reset while pending discards pending and clears active
        move("pre_rst", 200, 200);
        step("offer_rst", 1, 0, 0, 1, 0, 0, 300, 300);
        step("mid_rst", 0, 0, 1, 0, 210, 210, 0, 0);
        step("post_rst_fs", 1, 1, 1, 0, 5, 5, 0, 0);
        step("post_rst_scan", 1, 0, 0, 0, 300, 300, 0, 0);
        chk("rst_active_zero", 32'(pix_opaque), 32'd1);

        // Randomized operation
        tx = 100; ty = 50;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 31) == 0) begin
                tx = $urandom_range(0, 1023);
                ty = $urandom_range(0, 1023);
            end
            step("rand", ($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                 (tx + $urandom_range(0, 47) - 8) & 1023,
                 (ty + $urandom_range(0, 47) - 8) & 1023, tx, ty);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
